// File: rtl/mandelbrot_iter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mandelbrot_iter_ctrl
// Brief    : Mandelbrot escape-time iteration controller for an external step
//            ALU. Optional abort input enabled by macro MANDEL_ITER_ABORT_EN.
// Revision : 1.0
// ============================================================================
module mandelbrot_iter_ctrl #(
  parameter int WIDTH  = 8,
  parameter int ITER_W = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
`ifdef MANDEL_ITER_ABORT_EN
  input  logic                     abort,
`endif
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [WIDTH-1:0]  in_cr,
  input  logic signed [WIDTH-1:0]  in_ci,
  input  logic        [ITER_W-1:0] max_iter,
  output logic signed [WIDTH-1:0]  alu_cr,
  output logic signed [WIDTH-1:0]  alu_ci,
  output logic signed [WIDTH-1:0]  alu_zr,
  output logic signed [WIDTH-1:0]  alu_zi,
  input  logic signed [WIDTH-1:0]  alu_zr_next,
  input  logic signed [WIDTH-1:0]  alu_zi_next,
  input  logic                     alu_size,
  input  logic                     alu_overflow,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic        [ITER_W-1:0] iterations,
  output logic                     escaped
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic                      in_ready_q, in_ready_d;
  logic                      out_valid_q, out_valid_d;
  logic signed [WIDTH-1:0]   cr_q, cr_d;
  logic signed [WIDTH-1:0]   ci_q, ci_d;
  logic signed [WIDTH-1:0]   zr_q, zr_d;
  logic signed [WIDTH-1:0]   zi_q, zi_d;
  logic        [ITER_W-1:0]  count_q, count_d;
  logic        [ITER_W-1:0]  max_q, max_d;
  logic        [ITER_W-1:0]  iter_q, iter_d;
  logic                      esc_q, esc_d;
  logic                      abort_req;

`ifdef MANDEL_ITER_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    cr_d        = cr_q;
    ci_d        = ci_q;
    zr_d        = zr_q;
    zi_d        = zi_q;
    count_d     = count_q;
    max_d       = max_q;
    iter_d      = iter_q;
    esc_d       = esc_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          cr_d       = in_cr;
          ci_d       = in_ci;
          max_d      = max_iter;
          zr_d       = '0;
          zi_d       = '0;
          count_d    = '0;
          in_ready_d = 1'b0;
          state_d    = RUN;
        end
      end
      RUN: begin
        // Escape flags win over the limit so a diverging last step still reports escaped.
        if (alu_size || alu_overflow) begin
          iter_d      = count_q;
          esc_d       = 1'b1;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else if (count_q == max_q) begin
          iter_d      = count_q;
          esc_d       = 1'b0;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          zr_d    = alu_zr_next;
          zi_d    = alu_zi_next;
          count_d = count_q + ITER_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
    endcase

    if (abort_req && (state_q != IDLE)) begin
      out_valid_d = 1'b0;
      in_ready_d  = 1'b1;
      state_d     = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      cr_q        <= '0;
      ci_q        <= '0;
      zr_q        <= '0;
      zi_q        <= '0;
      count_q     <= '0;
      max_q       <= '0;
      iter_q      <= '0;
      esc_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      cr_q        <= cr_d;
      ci_q        <= ci_d;
      zr_q        <= zr_d;
      zi_q        <= zi_d;
      count_q     <= count_d;
      max_q       <= max_d;
      iter_q      <= iter_d;
      esc_q       <= esc_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign iterations = iter_q;
  assign escaped    = esc_q;
  assign alu_cr     = cr_q;
  assign alu_ci     = ci_q;
  assign alu_zr     = zr_q;
  assign alu_zi     = zi_q;

endmodule
`default_nettype wire
